hazard_scheduler: RTL and testbench
===================================

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 Parameter CNT_W, default 32: width of the stall and flush event counters.
REQ-002 Parameter ZERO_SEL, default 32'h00000001: one-hot select that means "no register write" (empty slot).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Aselect  input  32  one-hot A source of the instruction in ID.
REQ-006 Bselect  input  32  one-hot B source of the instruction in ID.
REQ-007 a_used, b_used  input  1 each  ID instruction actually reads that operand.
REQ-008 dsel_id  input  32  one-hot destination of the ID instruction; ZERO_SEL means none.
REQ-009 wr_id  input  1  ID instruction writes a register (low for store, branch, CB).
REQ-010 branch_taken  input  1  branch mux select from the ID-stage branch logic.
REQ-011 pc_en  output  1  PC load enable.
REQ-012 ifid_en  output  1  IF/ID register load enable.
REQ-013 idex_bubble  output  1  force ID/EX controls to a no-op (Dsel = ZERO_SEL, Load = Store = Branch = 0).
REQ-014 ifid_flush  output  1  replace the IF/ID content with a no-op on the next edge.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-016 Scoreboard: three 32-bit registers sb_ex, sb_mem, sb_wb hold the destinations of the instructions in EX, MEM and WB.
REQ-017 Every edge: sb_wb<=sb_mem and sb_mem<=sb_ex.
REQ-018 Every edge: sb_ex<=ZERO_SEL if the slot is a bubble or wr_id=0; otherwise sb_ex<=dsel_id.
REQ-019 busy = (sb_ex | sb_mem | sb_wb) & ~ZERO_SEL.
REQ-020 hazard = (a_used & |(Aselect & busy)) | (b_used & |(Bselect & busy)). No forwarding exists, so a WB-stage match is also a hazard.
REQ-021 FSM states: RUN, STALL, FLUSH.
REQ-022 RUN:
  - hazard=1 -> STALL.
  - else branch_taken=1 -> FLUSH.
  - else remain in RUN.
REQ-023 STALL:
  - outputs pc_en=0, ifid_en=0, idex_bubble=1.
  - hazard=0 -> RUN, re-evaluating branch_taken.
  - otherwise remain in STALL.
REQ-024 FLUSH:
  - lasts exactly one cycle; outputs ifid_flush=1, idex_bubble=1, pc_en=1.
  - then -> RUN.
REQ-025 Outputs are combinational from the state and hazard.
  - In RUN with hazard=1: the stall outputs are asserted in the same cycle, so stall latency is 0.
  - In RUN with hazard=0: pc_en=ifid_en=1, bubble=flush=0.
REQ-026 Simultaneous hazard and branch_taken: hazard wins and branch_taken is ignored, because operands are not yet valid.
REQ-027 Maximum stall length is 3 cycles, when the producer is in EX.
REQ-028 stall_cnt increments each cycle idex_bubble=1 due to a hazard.
REQ-029 flush_cnt increments once per FLUSH entry.
REQ-030 Both counters saturate at all-ones and never wrap.

Reset
REQ-031 reset=0 asynchronously forces:
  - state=RUN.
  - sb_ex=sb_mem=sb_wb=ZERO_SEL.
  - stall_cnt=flush_cnt=0.
REQ-032 Output values while reset is asserted: pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=0.
REQ-033 Reset asserted mid-STALL or mid-FLUSH abandons the operation; the next cycle after release is RUN with an empty scoreboard.

Structure
REQ-034 A shared package arm_pipe_pkg holds the state enum (RUN, STALL, FLUSH), ZERO_SEL and the default CNT_W.
REQ-035 Sub-module sel_overlap computes the one-hot select vs busy-mask overlap; it is instantiated twice, for A and B.

Verification
REQ-036 Scenario 1: release reset with no traffic.
  - Required: pc_en=1, ifid_en=1 and all counters 0 on the first cycle.
REQ-037 Scenario 2: load-use hazard.
  - Stimulus: issue dsel_id=32'h00000004 with wr_id=1, then the next ID instruction has Aselect=32'h00000004, a_used=1.
  - Required: 3 stall cycles (pc_en=0), stall_cnt=3, RUN resumes on the 4th cycle.
REQ-038 Scenario 3: write to ZERO_SEL.
  - Stimulus: dsel_id=32'h00000001 followed by Bselect=32'h00000001, b_used=1.
  - Required: no stall.
REQ-039 Scenario 4: taken branch with no hazard.
  - Stimulus: branch_taken=1.
  - Required: one FLUSH cycle with ifid_flush=1, flush_cnt=1, then RUN.
REQ-040 Scenario 5: simultaneous hazard and branch_taken.
  - Required: STALL first; FLUSH follows only if branch_taken is still 1 when the hazard clears.
REQ-041 Scenario 6: saturation and reset mid-stall.
  - Stimulus: preload with CNT_W=4 and force 20 stall cycles.
  - Required: stall_cnt holds at 4'hF.
  - Then assert reset=0 mid-stall. Required: immediate RUN, counters 0, scoreboard cleared.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the pipeline hazard control slice: scheduler
// states, the "no destination" one-hot select and the default counter width.
package arm_pipe_pkg;

  // Scheduler states. STALL holds the front end while a source register is
  // still in flight. FLUSH squashes the wrong-path fetch after a taken branch.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // One-hot select that names the hard-wired zero register. Writing it is a no-op.
  localparam logic [31:0] ZERO_SEL_DFLT = 32'h0000_0001;

  // Default width of the stall/flush event counters.
  localparam int CNT_W_DFLT = 32;

endpackage

// File: rtl/sel_overlap.sv
// Reports whether a one-hot operand select points at a register that is still
// waiting to be written by an older instruction. The hit is gated by the
// operand's "used" flag.
module sel_overlap #(
  parameter int W = 32
) (
  input  logic [W-1:0] sel,
  input  logic [W-1:0] busyMask,
  input  logic         used,
  output logic         hit
);

  // An unused operand never causes a hit, even if its select field is stale.
  always_comb begin
    hit = used & (|(sel & busyMask));
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Stall/flush scheduler for a non-forwarding 5-stage pipeline. A 3-deep
// destination scoreboard tracks the EX, MEM and WB stages. The scheduler
// stalls IF/ID while an ID operand is still in flight, and squashes one fetch
// after a taken branch. Saturating counters record the stall and flush events.
module hazard_scheduler
  import arm_pipe_pkg::*;
#(
  parameter int          CNT_W    = CNT_W_DFLT,
  parameter logic [31:0] ZERO_SEL = ZERO_SEL_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Aselect,
  input  logic [31:0]      Bselect,
  input  logic             a_used,
  input  logic             b_used,
  input  logic [31:0]      dsel_id,
  input  logic             wr_id,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t      state;
  state_t      nextState;
  logic [31:0] sbEx;
  logic [31:0] sbMem;
  logic [31:0] sbWb;
  logic [31:0] busy;
  logic        hitA;
  logic        hitB;
  logic        hazard;
  logic        stallEvt;
  logic        flushEvt;

  // Counters stick at all-ones rather than wrapping back to a small value.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Registers still owed a write. The zero register never blocks a reader.
  always_comb begin
    busy = (sbEx | sbMem | sbWb) & ~ZERO_SEL;
  end

  sel_overlap #(.W(32)) uOverlapA (
    .sel      (Aselect),
    .busyMask (busy),
    .used     (a_used),
    .hit      (hitA)
  );

  sel_overlap #(.W(32)) uOverlapB (
    .sel      (Bselect),
    .busyMask (busy),
    .used     (b_used),
    .hit      (hitB)
  );

  // There is no forwarding path, so a match in any of EX/MEM/WB holds the reader.
  always_comb begin
    hazard = hitA | hitB;
  end

  // Next state and front-end controls. A hazard takes effect in the same cycle,
  // and it wins over a taken branch whose operands are not yet valid.
  always_comb begin
    nextState   = RUN;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    stallEvt    = 1'b0;
    flushEvt    = 1'b0;
    case (state)
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        nextState   = RUN;
      end
      RUN, STALL: begin
        if (hazard) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          stallEvt    = 1'b1;
          nextState   = STALL;
        end else if (branch_taken) begin
          flushEvt  = 1'b1;
          nextState = FLUSH;
        end else begin
          nextState = RUN;
        end
      end
      default: begin
        nextState = RUN;
      end
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Destination scoreboard. It shifts every cycle. A bubble or a non-writing
  // instruction enters EX as an empty slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sbEx  <= ZERO_SEL;
      sbMem <= ZERO_SEL;
      sbWb  <= ZERO_SEL;
    end else begin
      sbWb  <= sbMem;
      sbMem <= sbEx;
      sbEx  <= (idex_bubble || !wr_id) ? ZERO_SEL : dsel_id;
    end
  end

  // Event counters: one stall count per hazard bubble, one flush count per FLUSH entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallEvt) begin
        stall_cnt <= satInc(stall_cnt);
      end
      if (flushEvt) begin
        flush_cnt <= satInc(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed-vector bench for hazard_scheduler. The driver applies one vector
// per cycle and queues the hand-computed outputs for that cycle. A monitor
// on the falling edge pops the queue and compares.
module tb_hazard_scheduler;

  localparam logic [31:0] ZS   = 32'h0000_0001;
  localparam logic [3:0]  RUNO = 4'b1100;  // {pc_en, ifid_en, idex_bubble, ifid_flush}
  localparam logic [3:0]  STLO = 4'b0010;
  localparam logic [3:0]  FLSO = 4'b1111;
  localparam logic [31:0] R2   = 32'h0000_0004;
  localparam logic [31:0] R3   = 32'h0000_0008;
  localparam logic [31:0] R16  = 32'h0001_0000;

  typedef struct {
    string      name;
    logic [3:0] ctl;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] Aselect;
  logic [31:0] Bselect;
  logic        a_used;
  logic        b_used;
  logic [31:0] dsel_id;
  logic        wr_id;
  logic        branch_taken;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_bubble;
  logic        ifid_flush;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;

  exp_t q[$];
  int   nTests = 0;
  int   nFail  = 0;

  hazard_scheduler #(.CNT_W(4), .ZERO_SEL(ZS)) dut (
    .clk          (clk),
    .reset        (reset),
    .Aselect      (Aselect),
    .Bselect      (Bselect),
    .a_used       (a_used),
    .b_used       (b_used),
    .dsel_id      (dsel_id),
    .wr_id        (wr_id),
    .branch_taken (branch_taken),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one cycle of inputs just after the rising edge and queues the outputs expected in that cycle.
  task automatic cyc(input string nm, input logic rstn,
                     input logic [31:0] a, input logic au,
                     input logic [31:0] b, input logic bu,
                     input logic [31:0] d, input logic w, input logic br,
                     input logic [3:0] ctl, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rstn;
    Aselect      = a;
    a_used       = au;
    Bselect      = b;
    b_used       = bu;
    dsel_id      = d;
    wr_id        = w;
    branch_taken = br;
    e.name = nm;
    e.ctl  = ctl;
    e.sc   = sc[3:0];
    e.fc   = fc[3:0];
    q.push_back(e);
  endtask

  // Compares the DUT outputs on the falling edge, away from the driving edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      nTests++;
      if ({pc_en, ifid_en, idex_bubble, ifid_flush} !== e.ctl ||
          stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        nFail++;
        $display("FAIL %s: got pc/if/bub/fl=%b stall=%0d flush=%0d, expected pc/if/bub/fl=%b stall=%0d flush=%0d",
                 e.name, {pc_en, ifid_en, idex_bubble, ifid_flush}, stall_cnt, flush_cnt,
                 e.ctl, e.sc, e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; Aselect = '0; Bselect = '0; a_used = 1'b0; b_used = 1'b0;
    dsel_id = ZS; wr_id = 1'b0; branch_taken = 1'b0;

    // Reset and release with no traffic.
    cyc("rst_hold",    0, '0, 0, '0, 0, ZS, 0, 0, RUNO, 0, 0);
    cyc("rst_release", 1, '0, 0, '0, 0, ZS, 0, 0, RUNO, 0, 0);

    // Load-use: the producer in EX gives three stall cycles.
    cyc("lu_prod",   1, '0, 0, '0, 0, R2, 1, 0, RUNO, 0, 0);
    cyc("lu_stall1", 1, R2, 1, '0, 0, ZS, 0, 0, STLO, 0, 0);
    cyc("lu_stall2", 1, R2, 1, '0, 0, ZS, 0, 0, STLO, 1, 0);
    cyc("lu_stall3", 1, R2, 1, '0, 0, ZS, 0, 0, STLO, 2, 0);
    cyc("lu_resume", 1, R2, 1, '0, 0, ZS, 0, 0, RUNO, 3, 0);
    cyc("lu_idle",   1, '0, 0, '0, 0, ZS, 0, 0, RUNO, 3, 0);

    // A write to the zero register never blocks a reader.
    cyc("zero_wr",   1, '0, 0, '0, 0, ZS, 1, 0, RUNO, 3, 0);
    cyc("zero_rd",   1, '0, 0, ZS, 1, ZS, 0, 0, RUNO, 3, 0);
    cyc("zero_idle", 1, '0, 0, '0, 0, ZS, 0, 0, RUNO, 3, 0);

    // Taken branch with no hazard: exactly one flush cycle.
    cyc("br_take",  1, '0, 0, '0, 0, ZS, 0, 1, RUNO, 3, 0);
    cyc("br_flush", 1, '0, 0, '0, 0, ZS, 0, 0, FLSO, 3, 1);
    cyc("br_after", 1, '0, 0, '0, 0, ZS, 0, 0, RUNO, 3, 1);

    // Hazard plus branch: stall first, then flush because the branch is still taken.
    cyc("hb_prod",   1, '0, 0, '0, 0, R3, 1, 0, RUNO, 3, 1);
    cyc("hb_stall1", 1, R3, 1, '0, 0, ZS, 0, 1, STLO, 3, 1);
    cyc("hb_stall2", 1, R3, 1, '0, 0, ZS, 0, 1, STLO, 4, 1);
    cyc("hb_stall3", 1, R3, 1, '0, 0, ZS, 0, 1, STLO, 5, 1);
    cyc("hb_clear",  1, R3, 1, '0, 0, ZS, 0, 1, RUNO, 6, 1);
    cyc("hb_flush",  1, '0, 0, '0, 0, ZS, 0, 0, FLSO, 6, 2);
    cyc("hb_after",  1, '0, 0, '0, 0, ZS, 0, 0, RUNO, 6, 2);

    // Hazard plus branch, where the branch drops before the hazard clears: no flush.
    cyc("hn_prod",   1, '0, 0, '0, 0, R3, 1, 0, RUNO, 6, 2);
    cyc("hn_stall1", 1, R3, 1, '0, 0, ZS, 0, 1, STLO, 6, 2);
    cyc("hn_stall2", 1, R3, 1, '0, 0, ZS, 0, 0, STLO, 7, 2);
    cyc("hn_stall3", 1, R3, 1, '0, 0, ZS, 0, 0, STLO, 8, 2);
    cyc("hn_clear",  1, R3, 1, '0, 0, ZS, 0, 0, RUNO, 9, 2);
    cyc("hn_noflush",1, '0, 0, '0, 0, ZS, 0, 0, RUNO, 9, 2);

    // B operand with the producer in MEM: two stall cycles. An unused operand never stalls.
    cyc("bm_prod",    1, '0, 0, '0,  0, R16, 1, 0, RUNO, 9, 2);
    cyc("bm_gap",     1, '0, 0, '0,  0, ZS,  0, 0, RUNO, 9, 2);
    cyc("bm_stall1",  1, '0, 0, R16, 1, ZS,  0, 0, STLO, 9, 2);
    cyc("bm_stall2",  1, '0, 0, R16, 1, ZS,  0, 0, STLO, 10, 2);
    cyc("bm_resume",  1, '0, 0, R16, 1, ZS,  0, 0, RUNO, 11, 2);
    cyc("bu_prod",    1, '0, 0, '0,  0, R16, 1, 0, RUNO, 11, 2);
    cyc("bu_unused",  1, '0, 0, R16, 0, ZS,  0, 0, RUNO, 11, 2);

    // Reset during FLUSH abandons the flush and clears both counters.
    cyc("rf_take",    1, '0, 0, '0, 0, ZS, 0, 1, RUNO, 11, 2);
    cyc("rf_reset",   0, '0, 0, '0, 0, ZS, 0, 0, RUNO, 0, 0);
    cyc("rf_release", 1, '0, 0, '0, 0, ZS, 0, 0, RUNO, 0, 0);

    // A self-dependent stream gives repeated 3-cycle stalls, and the 4-bit stall counter saturates.
    for (int k = 0; k < 30; k++) begin
      int n;
      n = 3 * (k / 4) + ((k % 4 == 0) ? 0 : (k % 4 - 1));
      if (n > 15) n = 15;
      cyc("sat", 1, R2, 1, '0, 0, R2, 1, 0, (k % 4 == 0) ? RUNO : STLO, n, 0);
    end

    // Reset mid-stall: RUN at once with counters and scoreboard cleared.
    cyc("rs_reset",   0, R2, 1, '0, 0, R2, 1, 0, RUNO, 0, 0);
    cyc("rs_release", 1, R2, 1, '0, 0, R2, 1, 0, RUNO, 0, 0);
    cyc("rs_rehaz",   1, R2, 1, '0, 0, R2, 1, 0, STLO, 0, 0);
    cyc("rs_idle",    1, '0, 0, '0, 0, ZS, 0, 0, RUNO, 1, 0);

    repeat (3) @(posedge clk);
    nTests++;
    if (q.size() != 0) begin
      nFail++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
